// File: rtl/timer_dev_pkg.sv
// Shared constants for the countdown timer peripheral: FSM encoding,
// register word offsets and CTRL bit positions.
package timer_dev_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CNT  = 2'd1,
    ST_INT  = 2'd2
  } state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_MODE = 1;
  localparam int unsigned CTRL_IM   = 3;

  // Only EN, MODE and IM are stored; every other CTRL bit reads 0.
  function automatic logic [31:0] ctrl_word(input logic en, input logic mode, input logic im);
    logic [31:0] w;
    w            = '0;
    w[CTRL_EN]   = en;
    w[CTRL_MODE] = mode;
    w[CTRL_IM]   = im;
    return w;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Programmable countdown timer with one-shot (held irq) and auto-reload
// (single-cycle periodic irq) modes behind a word-addressed register port.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   preset_q, preset_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               en_q, en_d;
  logic               mode_q, mode_d;
  logic               im_q, im_d;
  logic               pend_q, pend_d;
  logic               pend_set, pend_clr;
  logic               wr_ctrl, wr_preset;

  logic unused_din;
  assign unused_din = ^{din[31:4], din[2]};

  assign wr_ctrl   = we && (addr == OFF_CTRL);
  assign wr_preset = we && (addr == OFF_PRESET);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    pend_set = 1'b0;
    pend_clr = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en_q) begin
          count_d = preset_q;
          state_d = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          // A preset of 0 lands here too, so COUNT never wraps.
          count_d  = '0;
          pend_set = 1'b1;
          state_d  = ST_INT;
        end
      end
      ST_INT: begin
        if (!mode_q) begin
          en_d = 1'b0;
        end else begin
          pend_clr = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus writes override the one-shot EN clear issued from ST_INT.
    if (wr_ctrl) begin
      en_d   = din[CTRL_EN];
      mode_d = din[CTRL_MODE];
      im_d   = din[CTRL_IM];
    end
    if (wr_preset) begin
      preset_d = din[CNT_W-1:0];
    end

    // Any CTRL/PRESET write acknowledges, but a same-edge set is never lost.
    pend_d = pend_set | (pend_q & ~(pend_clr | wr_ctrl | wr_preset));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      preset_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      mode_q   <= 1'b0;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    dout = '0;
    unique case (addr)
      OFF_CTRL:   dout = ctrl_word(en_q, mode_q, im_q);
      OFF_PRESET: dout = 32'(preset_q);
      OFF_COUNT:  dout = 32'(count_q);
      default:    dout = '0;
    endcase
  end

  assign irq = im_q & pend_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: stimulus pushes expected reads/irq levels
// into a scoreboard queue, a monitor process pops and compares them.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  timer_dev #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          is_irq;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: drains the scoreboard whenever stimulus presents a value.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = e.is_irq ? {31'b0, irq} : dout;
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic chk_rd(input logic [1:0] a, input logic [31:0] v, input string nm);
    exp_t e;
    addr = a;
    #1;
    e = '{name: nm, exp: v, is_irq: 1'b0};
    sb.push_back(e);
    ->chk_ev;
    #1;
  endtask

  task automatic chk_irq(input logic v, input string nm);
    exp_t e;
    #1;
    e = '{name: nm, exp: {31'b0, v}, is_irq: 1'b1};
    sb.push_back(e);
    ->chk_ev;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    din   = '0;
    repeat (2) tick();
    chk_rd(2'd0, 32'h0, "rst_ctrl");
    chk_rd(2'd2, 32'h0, "rst_count");
    chk_irq(1'b0, "rst_irq");
    tick();
    reset = 1'b0;
    tick();

    // Asynchronous reset mid-count.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);
    tick();
    tick();
    chk_rd(2'd2, 32'd4, "midcount_count");
    tick();
    reset = 1'b1;
    chk_rd(2'd2, 32'h0, "arst_count");
    chk_irq(1'b0, "arst_irq");
    chk_rd(2'd0, 32'h0, "arst_ctrl");
    chk_rd(2'd1, 32'h0, "arst_preset");
    tick();
    reset = 1'b0;
    tick();

    // One-shot: irq held until acknowledged by a CTRL write.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    repeat (3) tick();
    chk_rd(2'd2, 32'd1, "os_count_e3");
    chk_irq(1'b0, "os_irq_e3");
    tick();
    chk_rd(2'd2, 32'd0, "os_count_e4");
    chk_irq(1'b1, "os_irq_e4");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_irq(1'b1, "os_irq_held");
    end
    chk_rd(2'd0, 32'h8, "os_ctrl_en_cleared");
    wr(2'd0, 32'h0);
    chk_irq(1'b0, "os_irq_ack");

    // Masked interrupt, then acknowledge with IM set and EN clear.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_irq(1'b0, "mask_irq");
    end
    chk_rd(2'd0, 32'h0, "mask_ctrl");
    wr(2'd0, 32'h8);
    chk_irq(1'b0, "mask_ack_irq");
    tick();
    chk_irq(1'b0, "mask_ack_irq2");

    // Auto-reload with PRESET=2: pulses after edges 3, 7, 11, ... of the enable write.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk_irq((c >= 3) && (((c - 3) % 4) == 0), "ar_irq");
      if ((c % 4) == 0) chk_rd(2'd0, 32'hB, "ar_ctrl");
    end
    wr(2'd0, 32'h0);
    tick();

    // Disable mid-count; the CTRL=0 write lands on the edge that takes COUNT 7 -> 6.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    repeat (4) tick();
    chk_rd(2'd2, 32'd7, "dis_count7");
    wr(2'd0, 32'h0);
    chk_rd(2'd2, 32'd6, "dis_count6");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_rd(2'd2, 32'd6, "dis_hold");
    end
    wr(2'd2, 32'h55);
    chk_rd(2'd2, 32'd6, "count_ro");
    wr(2'd3, 32'hFFFF_FFFF);
    chk_rd(2'd3, 32'h0, "off3_zero");
    chk_rd(2'd2, 32'd6, "count_ro3");
    chk_rd(2'd0, 32'h0, "ctrl_after_off3");
    wr(2'd0, 32'h1);
    tick();
    chk_rd(2'd2, 32'd10, "reen_reload");
    wr(2'd0, 32'h0);
    tick();

    // Collision: CTRL write on the edge that sets irq_pend; set wins.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    tick();
    wr(2'd0, 32'h9);
    chk_irq(1'b1, "col_set_wins");
    chk_rd(2'd2, 32'd0, "col_count");
    // CTRL write on the INT edge: bus keeps EN set and acknowledges the irq.
    wr(2'd0, 32'h9);
    chk_rd(2'd0, 32'h9, "col_bus_wins");
    chk_irq(1'b0, "col_ack");
    wr(2'd0, 32'h0);
    tick();

    // PRESET=0 behaves like 1: irq one cycle after the load.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick();
    chk_rd(2'd2, 32'd0, "p0_count");
    chk_irq(1'b0, "p0_irq_load");
    tick();
    chk_irq(1'b1, "p0_irq");
    wr(2'd0, 32'h0);
    chk_irq(1'b0, "p0_ack");

    tick();
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
